mainfsm: RTL

//   Moore main controller that sequences the multicycle ARM datapath. It steps

---
 rtl/mainfsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mainfsm.sv
// Moore main controller for the multicycle ARM datapath: sequences
// fetch/decode/execute/writeback with an optional bounded memory-ready stall.
module mainfsm #(
   parameter bit          WAIT_EN    = 1'b0,
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       MemFault,
   output logic [3:0] State
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_e;

   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
   } ctrl_t;

   // Control word for each state; illegal codes decode to all-zero.
   function automatic ctrl_t decode(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.next_pc    = 1'b1;
            c.alu_src_a  = 2'b01;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 2'b01;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_MEMADR:   c.alu_src_b = 2'b01;
         S_MEMRD:    c.adr_src   = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_w      = 1'b1;
         end
         S_MEMWR: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         S_EXECUTER: c.alu_op = 1'b1;
         S_EXECUTEI: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = 1'b1;
         end
         S_ALUWB:    c.reg_w = 1'b1;
         S_BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   state_e             state_q, state_d, nxt_c;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fault_q, fault_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic               mem_state_c, stall_c, timeout_c;
   logic               unused_funct_c;

   assign unused_funct_c = ^Funct[4:1];

   // Unstalled successor of the current state.
   always_comb begin
      nxt_c = S_FETCH;
      case (state_q)
         S_FETCH:  nxt_c = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   nxt_c = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   nxt_c = S_MEMADR;
               2'b10:   nxt_c = S_BRANCH;
               default: nxt_c = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   nxt_c = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    nxt_c = S_MEMWB;
         S_EXECUTER: nxt_c = S_ALUWB;
         S_EXECUTEI: nxt_c = S_ALUWB;
         default:    nxt_c = S_FETCH;
      endcase
   end

   // Stall / timeout handling layered over the plain sequence.
   always_comb begin
      state_d     = nxt_c;
      cnt_d       = '0;
      fault_d     = fault_q;
      mem_state_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      stall_c     = WAIT_EN && mem_state_c && !MemReady;
      timeout_c   = stall_c && (cnt_q == CNT_W'(WAIT_LIMIT));
      if (timeout_c) begin
         state_d = S_FETCH;
         fault_d = 1'b1;
      end else if (stall_c) begin
         state_d = state_q;
         cnt_d   = cnt_q + CNT_W'(1);
      end
      ctrl_d = decode(state_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         ctrl_q  <= decode(S_FETCH);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Write strobes are suppressed in the cycle a wait times out.
   assign IRWrite   = ctrl_q.ir_write & ~timeout_c;
   assign NextPC    = ctrl_q.next_pc  & ~timeout_c;
   assign MemW      = ctrl_q.mem_w    & ~timeout_c;
   assign AdrSrc    = ctrl_q.adr_src;
   assign ALUSrcA   = ctrl_q.alu_src_a;
   assign ALUSrcB   = ctrl_q.alu_src_b;
   assign ResultSrc = ctrl_q.result_src;
   assign RegW      = ctrl_q.reg_w;
   assign Branch    = ctrl_q.branch;
   assign ALUOp     = ctrl_q.alu_op;
   assign MemFault  = fault_q;
   assign State     = state_q;

endmodule
